// File: rtl/sram_col_model_if.sv
// Column control bundle between the column stimulus (master) and the column model (slave).
// Control inputs run toward the model; modelled bitline, sense and debug state run back.
interface sram_col_model_if #(
    parameter int ROWS = 4
);
    logic            preb;
    logic            w_en;
    logic            write_bit;
    logic            SAE;
    logic [ROWS-1:0] WL;
    logic [ROWS-1:0] WLB;
    logic            bl;
    logic            blb;
    logic            sa_out;
    logic            sa_valid;
    logic [ROWS-1:0] cell_q;
    logic [2:0]      err;
    logic [2:0]      state_o;

    modport master (
        output preb, w_en, write_bit, SAE, WL, WLB,
        input  bl, blb, sa_out, sa_valid, cell_q, err, state_o
    );

    modport slave (
        input  preb, w_en, write_bit, SAE, WL, WLB,
        output bl, blb, sa_out, sa_valid, cell_q, err, state_o
    );
endinterface

// File: rtl/sram_col_model.sv
// Clocked behavioural model of one SRAM column: cell storage, bitline precharge and
// wired-AND discharge, sense-amp latching and sticky protocol-violation flags.
module sram_col_model #(
    parameter int ROWS    = 4,
    parameter int PRE_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    sram_col_model_if.slave     col
);
    typedef enum logic [2:0] {
        ST_READY = 3'd0,
        ST_PRE   = 3'd1,
        ST_WRITE = 3'd2,
        ST_EVAL  = 3'd3,
        ST_SPENT = 3'd4
    } state_t;

    localparam int             CNT_W   = (PRE_CYC < 1) ? 1 : $clog2(PRE_CYC + 1);
    localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(PRE_CYC);

    state_t          r_state;
    logic [CNT_W-1:0] r_pre_cnt;
    logic [ROWS-1:0] r_cell;
    logic [ROWS-1:0] r_wl_last;
    logic [ROWS-1:0] r_wlb_last;
    logic            r_bl;
    logic            r_blb;
    logic            r_sa_out;
    logic            r_sa_valid;
    logic            r_sae_d;
    logic [2:0]      r_err;

    state_t          w_eff_state;
    logic            w_is_write;
    logic            w_is_read;
    logic            w_same_pat;
    logic            w_do_write;
    logic            w_do_eval;
    logic            w_sae_rise;
    logic [ROWS-1:0] w_wr_mask;
    logic [CNT_W-1:0] w_pre_inc;
    logic            w_bl_next;
    logic            w_blb_next;

    // Decode of the sampled cycle; only meaningful when preb=1.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_is_write = col.w_en && (|(col.WL | col.WLB));
        w_is_read  = !col.w_en && (|(col.WL | col.WLB));
        w_wr_mask  = col.WL & col.WLB;
        w_same_pat = (col.WL == r_wl_last) && (col.WLB == r_wlb_last);
        w_sae_rise = col.SAE && !r_sae_d;
        w_pre_inc  = (r_pre_cnt < PRE_MAX) ? r_pre_cnt + 1'b1 : r_pre_cnt;

        // Leaving PRE behaves like READY only if the lines got a full precharge.
        w_eff_state = r_state;
        if (r_state == ST_PRE) begin
            w_eff_state = (r_pre_cnt >= PRE_MAX) ? ST_READY : ST_SPENT;
        end

        w_do_write = w_is_write && (w_eff_state != ST_EVAL);
        w_do_eval  = w_is_read && ((w_eff_state == ST_READY) || (w_eff_state == ST_SPENT) ||
                                   ((w_eff_state == ST_EVAL) && w_same_pat));

        // Discharge only ever pulls a line low: wired-AND over the selected cells.
        w_bl_next  = r_bl;
        w_blb_next = r_blb;
        if (w_do_write) begin
            w_bl_next  = col.write_bit;
            w_blb_next = !col.write_bit;
        end else if (w_do_eval) begin
            w_bl_next  = r_bl  && (&(r_cell  | ~col.WL));
            w_blb_next = r_blb && (&(~r_cell | ~col.WLB));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_READY;
            r_pre_cnt  <= '0;
            // NOTE: the cell array is reset here because the model must start from known
            // contents; a real SRAM array would not be.
            r_cell     <= '0;
            r_wl_last  <= '0;
            r_wlb_last <= '0;
            r_bl       <= 1'b1;
            r_blb      <= 1'b1;
            r_sa_out   <= 1'b0;
            r_sa_valid <= 1'b0;
            r_sae_d    <= 1'b0;
            r_err      <= '0;
        end else begin
            r_sae_d    <= col.SAE;
            r_sa_valid <= 1'b0;

            if (!col.preb) begin
                r_state   <= ST_PRE;
                r_pre_cnt <= w_pre_inc;
                if (w_pre_inc == PRE_MAX) begin
                    r_bl  <= 1'b1;
                    r_blb <= 1'b1;
                end
            end else begin
                r_pre_cnt <= '0;
                r_bl      <= w_bl_next;
                r_blb     <= w_blb_next;

                if (w_do_write) begin
                    r_cell  <= (r_cell & ~w_wr_mask) | (w_wr_mask & {ROWS{col.write_bit}});
                    r_state <= ST_WRITE;
                end else if (w_do_eval) begin
                    r_wl_last  <= col.WL;
                    r_wlb_last <= col.WLB;
                    r_state    <= ST_EVAL;
                end else if (w_eff_state == ST_READY) begin
                    r_state <= ST_READY;
                end else begin
                    r_state <= ST_SPENT;
                end

                if (w_is_read && w_sae_rise) begin
                    r_sa_out   <= w_bl_next && w_blb_next;
                    r_sa_valid <= 1'b1;
                end

                if (w_do_eval && (w_eff_state == ST_SPENT)) begin
                    r_err[0] <= 1'b1;
                end
                if (col.w_en && col.SAE) begin
                    r_err[1] <= 1'b1;
                end
                if (w_is_write && (col.WL != col.WLB)) begin
                    r_err[2] <= 1'b1;
                end
            end
        end
    end

    assign col.bl       = r_bl;
    assign col.blb      = r_blb;
    assign col.sa_out   = r_sa_out;
    assign col.sa_valid = r_sa_valid;
    assign col.cell_q   = r_cell;
    assign col.err      = r_err;
    assign col.state_o  = r_state;
endmodule

// File: tb/tb_sram_col_model.sv
// Directed bench for sram_col_model: one task per scenario, inline comparisons against
// hand-computed values, one summary line at the end.
module tb_sram_col_model;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sram_col_model_if #(.ROWS(4)) col ();

    sram_col_model #(
        .ROWS    (4),
        .PRE_CYC (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .col (col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    // Apply one cycle of inputs, let the edge pass, return 1 time unit later.
    task automatic drive(input logic p, input logic we, input logic wb, input logic s,
                         input logic [3:0] wl, input logic [3:0] wlb);
        col.preb      = p;
        col.w_en      = we;
        col.write_bit = wb;
        col.SAE       = s;
        col.WL        = wl;
        col.WLB       = wlb;
        @(posedge clk);
        #1;
    endtask

    task automatic pre(input logic s);
        drive(1'b0, 1'b0, 1'b0, s, 4'b0000, 4'b0000);
    endtask

    task automatic nop(input logic s);
        drive(1'b1, 1'b0, 1'b0, s, 4'b0000, 4'b0000);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        nop(1'b0);
        nop(1'b0);
        rst = 1'b0;
        checks++; if (col.cell_q !== 4'b0000) begin errors++; $display("FAIL rst_cell got %b want 0000", col.cell_q); end
        checks++; if (col.bl !== 1'b1) begin errors++; $display("FAIL rst_bl got %b want 1", col.bl); end
        checks++; if (col.blb !== 1'b1) begin errors++; $display("FAIL rst_blb got %b want 1", col.blb); end
        checks++; if (col.sa_out !== 1'b0) begin errors++; $display("FAIL rst_sa_out got %b want 0", col.sa_out); end
        checks++; if (col.sa_valid !== 1'b0) begin errors++; $display("FAIL rst_sa_valid got %b want 0", col.sa_valid); end
        checks++; if (col.err !== 3'b000) begin errors++; $display("FAIL rst_err got %b want 000", col.err); end
        checks++; if (col.state_o !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", col.state_o); end
    endtask

    task automatic test_write_basic;
        pre(1'b0);
        checks++; if (col.state_o !== 3'd1) begin errors++; $display("FAIL t1_pre_state got %0d want 1", col.state_o); end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001);
        checks++; if (col.state_o !== 3'd2) begin errors++; $display("FAIL t1_state got %0d want 2", col.state_o); end
        checks++; if (col.cell_q !== 4'b0000) begin errors++; $display("FAIL t1_cell got %b want 0000", col.cell_q); end
        checks++; if (col.bl !== 1'b0) begin errors++; $display("FAIL t1_bl got %b want 0", col.bl); end
        checks++; if (col.blb !== 1'b1) begin errors++; $display("FAIL t1_blb got %b want 1", col.blb); end
        checks++; if (col.err !== 3'b000) begin errors++; $display("FAIL t1_err got %b want 000", col.err); end
    endtask

    task automatic test_read_sense;
        pre(1'b0);
        checks++; if (col.bl !== 1'b1) begin errors++; $display("FAIL t2_pre_bl got %b want 1", col.bl); end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0000);
        checks++; if (col.state_o !== 3'd3) begin errors++; $display("FAIL t2_state got %0d want 3", col.state_o); end
        checks++; if (col.bl !== 1'b0) begin errors++; $display("FAIL t2_bl got %b want 0", col.bl); end
        checks++; if (col.sa_out !== 1'b0) begin errors++; $display("FAIL t2_sa_out got %b want 0", col.sa_out); end
        checks++; if (col.sa_valid !== 1'b1) begin errors++; $display("FAIL t2_sa_valid got %b want 1", col.sa_valid); end
        nop(1'b0);
        checks++; if (col.sa_valid !== 1'b0) begin errors++; $display("FAIL t2_pulse got %b want 0", col.sa_valid); end
        checks++; if (col.state_o !== 3'd4) begin errors++; $display("FAIL t2_spent got %0d want 4", col.state_o); end
        pre(1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001);
        checks++; if (col.blb !== 1'b1) begin errors++; $display("FAIL t2b_blb got %b want 1", col.blb); end
        checks++; if (col.sa_out !== 1'b1) begin errors++; $display("FAIL t2b_sa_out got %b want 1", col.sa_out); end
        nop(1'b0);
    endtask

    task automatic test_write_read;
        pre(1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 4'b0010);
        checks++; if (col.cell_q !== 4'b0010) begin errors++; $display("FAIL t3_cell got %b want 0010", col.cell_q); end
        checks++; if (col.blb !== 1'b0) begin errors++; $display("FAIL t3_wr_blb got %b want 0", col.blb); end
        nop(1'b0);
        pre(1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000);
        checks++; if (col.sa_out !== 1'b1) begin errors++; $display("FAIL t3_rd_wl got %b want 1", col.sa_out); end
        nop(1'b0);
        pre(1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0010);
        checks++; if (col.blb !== 1'b0) begin errors++; $display("FAIL t3_rd_blb got %b want 0", col.blb); end
        checks++; if (col.sa_out !== 1'b0) begin errors++; $display("FAIL t3_rd_wlb got %b want 0", col.sa_out); end
        nop(1'b0);
    endtask

    task automatic test_back_to_back;
        pre(1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0001);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0010, 4'b0010);
        checks++; if (col.state_o !== 3'd2) begin errors++; $display("FAIL t4_wr_state got %0d want 2", col.state_o); end
        checks++; if (col.cell_q !== 4'b0011) begin errors++; $display("FAIL t4_cell got %b want 0011", col.cell_q); end
        nop(1'b0);
        pre(1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, 4'b0000);
        checks++; if (col.bl !== 1'b1) begin errors++; $display("FAIL t4_bl got %b want 1", col.bl); end
        checks++; if (col.sa_out !== 1'b1) begin errors++; $display("FAIL t4_sa_out got %b want 1", col.sa_out); end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, 4'b0000);
        checks++; if (col.state_o !== 3'd3) begin errors++; $display("FAIL t4_hold_state got %0d want 3", col.state_o); end
        checks++; if (col.sa_valid !== 1'b0) begin errors++; $display("FAIL t4_hold_valid got %b want 0", col.sa_valid); end
        nop(1'b0);
        nop(1'b1);
        checks++; if (col.sa_valid !== 1'b0) begin errors++; $display("FAIL t4_nop_sae got %b want 0", col.sa_valid); end
        nop(1'b0);
        pre(1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0111, 4'b0000);
        checks++; if (col.bl !== 1'b0) begin errors++; $display("FAIL t4_and_bl got %b want 0", col.bl); end
        checks++; if (col.sa_out !== 1'b0) begin errors++; $display("FAIL t4_and_sa got %b want 0", col.sa_out); end
        checks++; if (col.err !== 3'b000) begin errors++; $display("FAIL t4_err got %b want 000", col.err); end
        nop(1'b0);
    endtask

    task automatic test_spent_read;
        pre(1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000);
        checks++; if (col.err !== 3'b000) begin errors++; $display("FAIL t5_first_err got %b want 000", col.err); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000);
        checks++; if (col.state_o !== 3'd4) begin errors++; $display("FAIL t5_change got %0d want 4", col.state_o); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000);
        checks++; if (col.state_o !== 3'd3) begin errors++; $display("FAIL t5_state got %0d want 3", col.state_o); end
        checks++; if (col.err !== 3'b001) begin errors++; $display("FAIL t5_err got %b want 001", col.err); end
        pre(1'b0);
        nop(1'b0);
        checks++; if (col.state_o !== 3'd0) begin errors++; $display("FAIL t5_ready got %0d want 0", col.state_o); end
        checks++; if (col.err !== 3'b001) begin errors++; $display("FAIL t5_sticky got %b want 001", col.err); end
    endtask

    task automatic test_sae_during_pre;
        rst = 1'b1;
        nop(1'b0);
        rst = 1'b0;
        pre(1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0000);
        checks++; if (col.state_o !== 3'd3) begin errors++; $display("FAIL tp_state got %0d want 3", col.state_o); end
        checks++; if (col.bl !== 1'b0) begin errors++; $display("FAIL tp_bl got %b want 0", col.bl); end
        checks++; if (col.sa_valid !== 1'b0) begin errors++; $display("FAIL tp_valid got %b want 0", col.sa_valid); end
        nop(1'b0);
    endtask

    task automatic test_errors_reset;
        rst = 1'b1;
        nop(1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b0000);
        checks++; if (col.err !== 3'b110) begin errors++; $display("FAIL t6_err got %b want 110", col.err); end
        checks++; if (col.cell_q !== 4'b0000) begin errors++; $display("FAIL t6_cell got %b want 0000", col.cell_q); end
        checks++; if (col.sa_valid !== 1'b0) begin errors++; $display("FAIL t6_valid got %b want 0", col.sa_valid); end
        nop(1'b0);
        pre(1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0001);
        checks++; if (col.cell_q !== 4'b0001) begin errors++; $display("FAIL t6_wr_cell got %b want 0001", col.cell_q); end
        nop(1'b0);
        pre(1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0000);
        checks++; if (col.sa_out !== 1'b1) begin errors++; $display("FAIL t6_sa_out got %b want 1", col.sa_out); end
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0000);
        rst = 1'b0;
        checks++; if (col.cell_q !== 4'b0000) begin errors++; $display("FAIL t6_rst_cell got %b want 0000", col.cell_q); end
        checks++; if (col.bl !== 1'b1) begin errors++; $display("FAIL t6_rst_bl got %b want 1", col.bl); end
        checks++; if (col.sa_out !== 1'b0) begin errors++; $display("FAIL t6_rst_sa got %b want 0", col.sa_out); end
        checks++; if (col.err !== 3'b000) begin errors++; $display("FAIL t6_rst_err got %b want 000", col.err); end
        checks++; if (col.state_o !== 3'd0) begin errors++; $display("FAIL t6_rst_state got %0d want 0", col.state_o); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        col.preb      = 1'b1;
        col.w_en      = 1'b0;
        col.write_bit = 1'b0;
        col.SAE       = 1'b0;
        col.WL        = 4'b0000;
        col.WLB       = 4'b0000;

        test_reset();
        test_write_basic();
        test_read_sense();
        test_write_read();
        test_back_to_back();
        test_spent_read();
        test_sae_during_pre();
        test_errors_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
